vga_timing_rx: RTL
==================

// Module: vga_timing_rx
// PURPOSE
//  Sink-side counterpart of the VGA timing generator: consumes hsync/vsync on pix_clk, recovers
//  pixel coordinates, measures line/frame length and declares lock. Used as a loopback checker
//  on the generator's outputs and as the timing front end of future video-capture paths.
// PARAMETERS
//  H_SYNC_WIDTH   112   hsync pulse width, pixels
//  H_BACK_PORCH   248   pixels from hsync leading edge+H_SYNC_WIDTH to first active pixel
//  H_ACTIVE       1280  active pixels per line
//  H_TOTALS       1688  expected pixels per line
//  V_SYNC_WIDTH   3     vsync pulse width, lines
//  V_BACK_PORCH   38    lines after vsync pulse to first active line
//  V_ACTIVE       1024  active lines per frame
//  V_TOTALS       1066  expected lines per frame
//  SYNC_POL       1     1: sync pulse is high; 0: sync pulse is low
//  LOCK_FRAMES    2     consecutive matching frames required to lock (1..15)
// PORTS
//  pix_clk        in   1   pixel clock, sole clock
//  pix_rst_n      in   1   reset, synchronous, active-low
//  hsync          in   1   horizontal sync (SYNC_POL)
//  vsync          in   1   vertical sync (SYNC_POL)
//  pix_x          out  12  active column 0..H_ACTIVE-1; 0 when pix_valid=0
//  pix_y          out  12  active line 0..V_ACTIVE-1; 0 when pix_valid=0
//  pix_valid      out  1   active-region pixel, only while locked
//  frame_start    out  1   1-cycle pulse at each detected frame edge
//  locked         out  1   timing matches parameters
//  h_total_meas   out  12  length of last complete line, pixels
//  v_total_meas   out  12  length of last complete frame, lines
//  err_cnt        out  8   lock-loss events, saturates at 255
// BEHAVIOUR
//  - Reset (pix_rst_n=0 at posedge): all outputs 0, FSM=SEARCH, counters/sync flops 0; reset wins over all events.
//  - Inputs pass 2 flops (s1,s2), polarity-normalised. h_edge = s1 & ~s2 (pulse leading edge).
//  - h_cnt: on h_edge <= 0, else +1, saturating at 2*H_TOTALS-1. h_cnt==0 two cycles after first pin-asserted cycle.
//  - On h_edge: h_total_meas <= h_cnt+1 (skip update if h_cnt saturated); v_cnt += 1 (saturate 2*V_TOTALS-1).
//  - Frame edge = h_edge & vs_s1 & ~vs_line, vs_line = vs_s1 latched at each h_edge. vsync asserting on the
//    same cycle as hsync (generator behaviour) is a frame edge. On frame edge: v_total_meas <= v_cnt+1, v_cnt <= 0,
//    frame_start=1 next cycle.
//  - FSM (2-bit): SEARCH: wait frame edge -> CHECK, match_cnt=0.
//    CHECK: on h_edge with h_cnt+1 != H_TOTALS -> SEARCH; on frame edge, v_cnt+1==V_TOTALS -> match_cnt+1,
//    else match_cnt=0; match_cnt reaching LOCK_FRAMES -> LOCKED.
//    LOCKED: line-length mismatch, frame-length mismatch, or either counter saturating -> SEARCH, err_cnt+1.
//  - locked=1 exactly in LOCKED (registered from state).
//  - Active: h_cnt in [H_SYNC_WIDTH+H_BACK_PORCH, +H_ACTIVE-1], v_cnt in [V_SYNC_WIDTH+V_BACK_PORCH,
//    +V_ACTIVE-1]; pix_x/pix_y = offsets, registered. Pin-to-pix_* latency 3 cycles, fixed.
//  - Exactly H_ACTIVE x V_ACTIVE valid pixels per locked frame. Lock loss drops pix_valid the cycle after detection.
//  - Arithmetic unsigned 12-bit; parameter sums fit 12 bits (elaboration check).
// STRUCTURE
//  - vga_timing_defs.vh: default timing constants (shared with the generator), FSM encodings
//    SEARCH=0, CHECK=1, LOCKED=2.
//  - Sub-module sync_edge_det: 2-flop sync + polarity + leading-edge pulse; instantiated for hsync, vsync.
//  - Top: counters, measurement regs, FSM, coordinate output regs.
// TESTING
//  1 Generator loopback, defaults: locked=1 after 3rd frame edge; pix_valid 1280x1024/frame; first valid
//    pix_x=0,pix_y=0 at line 41, h_cnt 360; h_total_meas=1688, v_total_meas=1066.
//  2 Locked, one line shortened to 1687 -> locked=0 next cycle, err_cnt=1, pix_valid=0; relock after 2 frames.
//  3 hsync held inactive 4000 cycles while locked -> h_cnt saturates at 3375, SEARCH, err_cnt+1, no h_total_meas update.
//  4 Frame of 1065 lines -> lock lost at that frame edge; v_total_meas=1065.
//  5 pix_rst_n=0 mid-frame for 1 cycle -> all outputs 0 next cycle; relock after 3 frame edges.
//  6 SYNC_POL=0, inverted syncs -> identical results to scenario 1.

Source files
------------

// File: rtl/vga_timing_rx_pkg.sv
// Shared timing defaults and receiver state encodings for the VGA timing sink.
package vga_timing_rx_pkg;

    localparam int unsigned H_SYNC_WIDTH_DEF = 112;
    localparam int unsigned H_BACK_PORCH_DEF = 248;
    localparam int unsigned H_ACTIVE_DEF     = 1280;
    localparam int unsigned H_TOTALS_DEF     = 1688;
    localparam int unsigned V_SYNC_WIDTH_DEF = 3;
    localparam int unsigned V_BACK_PORCH_DEF = 38;
    localparam int unsigned V_ACTIVE_DEF     = 1024;
    localparam int unsigned V_TOTALS_DEF     = 1066;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    function automatic logic [11:0] sat_inc(
        input logic [11:0] v,
        input logic [11:0] max
    );
        return (v == max) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/vga_timing_rx_sync_edge_det.sv
// Two-flop synchroniser with polarity normalisation and leading-edge pulse.
module vga_timing_rx_sync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= (pin_i == POL);
            s2_q <= s1_q;
        end
    end

    assign level_o = s1_q;
    assign edge_o  = s1_q & ~s2_q;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers coordinates from hsync/vsync, measures
// line/frame length and declares lock after consecutive matching frames.
module vga_timing_rx
    import vga_timing_rx_pkg::*;
#(
    parameter int unsigned H_SYNC_WIDTH = H_SYNC_WIDTH_DEF,
    parameter int unsigned H_BACK_PORCH = H_BACK_PORCH_DEF,
    parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned H_TOTALS     = H_TOTALS_DEF,
    parameter int unsigned V_SYNC_WIDTH = V_SYNC_WIDTH_DEF,
    parameter int unsigned V_BACK_PORCH = V_BACK_PORCH_DEF,
    parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
    parameter int unsigned V_TOTALS     = V_TOTALS_DEF,
    parameter bit          SYNC_POL     = 1'b1,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input  logic        pix_clk,
    input  logic        pix_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] h_total_meas,
    output logic [11:0] v_total_meas,
    output logic [7:0]  err_cnt
);

    if (2 * H_TOTALS - 1 > 4095 || 2 * V_TOTALS - 1 > 4095 ||
        H_SYNC_WIDTH + H_BACK_PORCH + H_ACTIVE > H_TOTALS ||
        V_SYNC_WIDTH + V_BACK_PORCH + V_ACTIVE > V_TOTALS ||
        LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_param_err
        $error("vga_timing_rx: timing parameters out of range");
    end

    localparam logic [11:0] HT   = 12'(H_TOTALS);
    localparam logic [11:0] VT   = 12'(V_TOTALS);
    localparam logic [11:0] HMAX = 12'(2 * H_TOTALS - 1);
    localparam logic [11:0] VMAX = 12'(2 * V_TOTALS - 1);
    localparam logic [11:0] HA0  = 12'(H_SYNC_WIDTH + H_BACK_PORCH);
    localparam logic [11:0] HA1  = 12'(H_SYNC_WIDTH + H_BACK_PORCH + H_ACTIVE - 1);
    localparam logic [11:0] VA0  = 12'(V_SYNC_WIDTH + V_BACK_PORCH);
    localparam logic [11:0] VA1  = 12'(V_SYNC_WIDTH + V_BACK_PORCH + V_ACTIVE - 1);
    localparam logic [3:0]  LF   = 4'(LOCK_FRAMES);

    logic h_edge, hs_lvl, vs_edge, vs_lvl;
    logic unused_sync;

    vga_timing_rx_sync_edge_det #(.POL(SYNC_POL)) u_hs (
        .clk_i   (pix_clk),
        .rst_ni  (pix_rst_n),
        .pin_i   (hsync),
        .level_o (hs_lvl),
        .edge_o  (h_edge)
    );

    vga_timing_rx_sync_edge_det #(.POL(SYNC_POL)) u_vs (
        .clk_i   (pix_clk),
        .rst_ni  (pix_rst_n),
        .pin_i   (vsync),
        .level_o (vs_lvl),
        .edge_o  (vs_edge)
    );

    assign unused_sync = hs_lvl ^ vs_edge;

    rx_state_e   state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        vs_line_q, vs_line_d, fs_q, fs_d;
    logic        valid_q, valid_d, locked_q, locked_d;
    logic [7:0]  err_q, err_d;
    logic [3:0]  match_q, match_d;

    logic [11:0] h_len, v_len;
    logic        h_sat, v_sat, frame_edge, line_bad, frame_bad;
    logic        h_act, v_act;

    assign h_len      = h_cnt_q + 12'd1;
    assign v_len      = v_cnt_q + 12'd1;
    assign h_sat      = (h_cnt_q == HMAX);
    assign v_sat      = (v_cnt_q == VMAX);
    // Frame edge is the first line whose hsync sees vsync asserted.
    assign frame_edge = h_edge & vs_lvl & ~vs_line_q;
    assign line_bad   = h_edge & (h_len != HT);
    assign frame_bad  = frame_edge & (v_len != VT);

    always_comb begin
        h_cnt_d   = h_edge ? 12'd0 : sat_inc(h_cnt_q, HMAX);
        h_meas_d  = (h_edge && !h_sat) ? h_len : h_meas_q;
        vs_line_d = h_edge ? vs_lvl : vs_line_q;
        v_cnt_d   = v_cnt_q;
        v_meas_d  = v_meas_q;
        fs_d      = frame_edge;
        if (frame_edge) begin
            v_cnt_d  = 12'd0;
            v_meas_d = v_len;
        end else if (h_edge) begin
            v_cnt_d  = sat_inc(v_cnt_q, VMAX);
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        err_d   = err_q;
        unique case (state_q)
            ST_SEARCH: begin
                if (frame_edge) begin
                    state_d = ST_CHECK;
                    match_d = 4'd0;
                end
            end
            ST_CHECK: begin
                if (line_bad) begin
                    state_d = ST_SEARCH;
                end else if (frame_edge) begin
                    if (v_len == VT) begin
                        match_d = match_q + 4'd1;
                        if (match_d == LF) state_d = ST_LOCKED;
                    end else begin
                        match_d = 4'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_bad || frame_bad || h_sat || v_sat) begin
                    state_d = ST_SEARCH;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        h_act    = (h_cnt_q >= HA0) && (h_cnt_q <= HA1);
        v_act    = (v_cnt_q >= VA0) && (v_cnt_q <= VA1);
        locked_d = (state_d == ST_LOCKED);
        valid_d  = h_act && v_act && locked_d;
        x_d      = valid_d ? h_cnt_q - HA0 : 12'd0;
        y_d      = valid_d ? v_cnt_q - VA0 : 12'd0;
    end

    always_ff @(posedge pix_clk) begin
        if (!pix_rst_n) begin
            state_q   <= ST_SEARCH;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_meas_q  <= '0;
            v_meas_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vs_line_q <= 1'b0;
            fs_q      <= 1'b0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= '0;
            match_q   <= '0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_meas_q  <= h_meas_d;
            v_meas_q  <= v_meas_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vs_line_q <= vs_line_d;
            fs_q      <= fs_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            match_q   <= match_d;
        end
    end

    assign pix_x        = x_q;
    assign pix_y        = y_q;
    assign pix_valid    = valid_q;
    assign frame_start  = fs_q;
    assign locked       = locked_q;
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;
    assign err_cnt      = err_q;

endmodule
